// File: rtl/ram_stream_fifo_ctrl.sv
// Streaming FIFO controller in front of a single-port-per-direction synchronous RAM.
// A small output buffer absorbs RAM read latency so push and pop can both run every cycle.
module ram_stream_fifo_ctrl #(
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned WIDTH      = 128,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [WIDTH-1:0]      push_payload,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [WIDTH-1:0]      pop_payload,
    output logic [ADDR_WIDTH+1:0] occupancy,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [WIDTH-1:0]      ram_wr_data,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [WIDTH-1:0]      ram_rd_data
);

    localparam int unsigned PW     = ADDR_WIDTH + 1;
    localparam int unsigned OW     = ADDR_WIDTH + 2;
    localparam int unsigned OBUF_N = RD_LATENCY + 1;
    localparam int unsigned IW     = (OBUF_N > 2) ? $clog2(OBUF_N) : 1;
    localparam int unsigned CW     = $clog2(OBUF_N + 1);
    localparam int unsigned SW     = CW + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [RD_LATENCY-1:0] sr_q, sr_d;
    logic [WIDTH-1:0]      obuf_q [OBUF_N];
    logic [WIDTH-1:0]      obuf_d [OBUF_N];
    logic [IW-1:0]         head_q, head_d;
    logic [IW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         obuf_cnt_q, obuf_cnt_d;

    logic [PW-1:0]         ram_count;
    logic [CW-1:0]         inflight;
    logic                  ret;
    logic                  push_fire;
    logic                  pop_fire;
    logic                  rd_fire;
    logic                  has_slot;

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
        return (idx == IW'(OBUF_N - 1)) ? '0 : idx + IW'(1);
    endfunction

    // Handshake and read-issue decisions; all derived from registered state.
    always_comb begin
        ram_count = wr_ptr_q - rd_ptr_q;
        inflight  = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight = inflight + CW'(sr_q[i]);
        end
        ret        = sr_q[RD_LATENCY-1];
        push_ready = (ram_count < PW'(DEPTH));
        pop_valid  = (obuf_cnt_q != '0) && !reset;
        pop_fire   = pop_valid && pop_ready;
        push_fire  = push_valid && push_ready && !reset;
        // A pop this cycle frees a buffer slot for a read issued this cycle.
        has_slot   = ((SW'(obuf_cnt_q) + SW'(inflight)) < SW'(OBUF_N)) || pop_fire;
        rd_fire    = (ram_count != '0) && has_slot && !reset;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(push_fire);
        rd_ptr_d   = rd_ptr_q + PW'(rd_fire);
        sr_d       = RD_LATENCY'({sr_q, rd_fire});
        obuf_d     = obuf_q;
        head_d     = head_q;
        tail_d     = tail_q;
        obuf_cnt_d = obuf_cnt_q + CW'(ret) - CW'(pop_fire);
        if (ret) begin
            obuf_d[tail_q] = ram_rd_data;
            tail_d         = idx_inc(tail_q);
        end
        if (pop_fire) begin
            head_d = idx_inc(head_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sr_q       <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            obuf_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sr_q       <= sr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            obuf_cnt_q <= obuf_cnt_d;
        end
    end

    // Buffer storage carries no reset; validity lives in obuf_cnt_q.
    always_ff @(posedge clk) begin
        obuf_q <= obuf_d;
    end

    assign pop_payload = obuf_q[head_q];
    assign occupancy   = reset ? '0 : (OW'(ram_count) + OW'(inflight) + OW'(obuf_cnt_q));
    assign ram_wr_en   = push_fire;
    assign ram_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_wr_data = push_payload;
    assign ram_rd_en   = rd_fire;
    assign ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_ram_stream_fifo_ctrl.sv
// Bench for ram_stream_fifo_ctrl: two instances (read latency 1 and 2) share stimulus,
// each backed by a RAM model and checked against a word-count/queue reference.
module tb_ram_stream_fifo_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned AW    = 2;
    localparam int unsigned SBN   = 4096;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             push_valid = 1'b0;
    logic             pop_ready = 1'b0;
    logic [WIDTH-1:0] push_payload = '0;

    logic             push_ready  [2];
    logic             pop_valid   [2];
    logic [WIDTH-1:0] pop_payload [2];
    logic [AW+1:0]    occupancy   [2];
    logic             ram_wr_en   [2];
    logic [AW-1:0]    ram_wr_addr [2];
    logic [WIDTH-1:0] ram_wr_data [2];
    logic             ram_rd_en   [2];
    logic [AW-1:0]    ram_rd_addr [2];
    logic [WIDTH-1:0] ram_rd_data [2];

    always #5 clk = ~clk;

    ram_stream_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW), .RD_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready[0]), .push_payload(push_payload),
        .pop_valid(pop_valid[0]), .pop_ready(pop_ready), .pop_payload(pop_payload[0]),
        .occupancy(occupancy[0]),
        .ram_wr_en(ram_wr_en[0]), .ram_wr_addr(ram_wr_addr[0]), .ram_wr_data(ram_wr_data[0]),
        .ram_rd_en(ram_rd_en[0]), .ram_rd_addr(ram_rd_addr[0]), .ram_rd_data(ram_rd_data[0])
    );

    ram_stream_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW), .RD_LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready[1]), .push_payload(push_payload),
        .pop_valid(pop_valid[1]), .pop_ready(pop_ready), .pop_payload(pop_payload[1]),
        .occupancy(occupancy[1]),
        .ram_wr_en(ram_wr_en[1]), .ram_wr_addr(ram_wr_addr[1]), .ram_wr_data(ram_wr_data[1]),
        .ram_rd_en(ram_rd_en[1]), .ram_rd_addr(ram_rd_addr[1]), .ram_rd_data(ram_rd_data[1])
    );

    // RAM models; read data is random garbage except exactly RD_LATENCY cycles after a read.
    logic [WIDTH-1:0] mem [2][DEPTH];
    logic [WIDTH-1:0] p1 [2];
    logic [WIDTH-1:0] p2 [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ram_wr_en[i]) mem[i][ram_wr_addr[i]] <= ram_wr_data[i];
            p1[i] <= ram_rd_en[i] ? mem[i][ram_rd_addr[i]] : WIDTH'($urandom);
            p2[i] <= p1[i];
        end
    end

    assign ram_rd_data[0] = p1[0];
    assign ram_rd_data[1] = p2[1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic string tg(input int i, input string s);
        return $sformatf("lat%0d.%s", i + 1, s);
    endfunction

    // Reference: words accepted vs popped, plus RAM words written vs read.
    logic [WIDTH-1:0] sb [2][SBN];
    int               wcnt [2];
    int               rcnt [2];
    int               rw [2];
    int               rr [2];
    int               awrap [2];
    logic             prev_stall [2];
    logic [WIDTH-1:0] prev_pay [2];
    logic             obs_pv [2];
    logic             obs_pr [2];
    logic [AW+1:0]    obs_occ [2];
    logic             fp [2];
    logic             fo [2];

    function automatic int max_occ(input int i);
        return int'(DEPTH) + 2 + i;
    endfunction

    // One clock: observe and check at the falling edge, then step past the rising edge.
    task automatic cyc();
        int cnt;
        int ramc;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            obs_pv[i]  = pop_valid[i];
            obs_pr[i]  = push_ready[i];
            obs_occ[i] = occupancy[i];
            check_eq(tg(i, "wr_en"), 32'(ram_wr_en[i]), 32'(push_valid && push_ready[i] && !reset));
            if (reset) begin
                check_eq(tg(i, "rst_pv"), 32'(pop_valid[i]), 32'd0);
                check_eq(tg(i, "rst_occ"), 32'(occupancy[i]), 32'd0);
                check_eq(tg(i, "rst_rd_en"), 32'(ram_rd_en[i]), 32'd0);
                wcnt[i] = 0; rcnt[i] = 0; rw[i] = 0; rr[i] = 0;
                prev_stall[i] = 1'b0; fp[i] = 1'b0; fo[i] = 1'b0;
            end else begin
                cnt  = wcnt[i] - rcnt[i];
                ramc = rw[i] - rr[i];
                check_eq(tg(i, "occ"), 32'(occupancy[i]), 32'(cnt));
                check_eq(tg(i, "occ_max"), 32'(int'(occupancy[i]) <= max_occ(i)), 32'd1);
                if (cnt < int'(DEPTH)) check_eq(tg(i, "pr_free"), 32'(push_ready[i]), 32'd1);
                if (cnt == max_occ(i)) check_eq(tg(i, "pr_full"), 32'(push_ready[i]), 32'd0);
                if (cnt == 0) check_eq(tg(i, "pv_empty"), 32'(pop_valid[i]), 32'd0);
                if (pop_valid[i]) check_eq(tg(i, "pay"), 32'(pop_payload[i]), 32'(sb[i][rcnt[i] % SBN]));
                if (prev_stall[i]) begin
                    check_eq(tg(i, "stall_pv"), 32'(pop_valid[i]), 32'd1);
                    check_eq(tg(i, "stall_pay"), 32'(pop_payload[i]), 32'(prev_pay[i]));
                end
                if (ram_rd_en[i]) begin
                    check_eq(tg(i, "rd_nonempty"), 32'(ramc > 0), 32'd1);
                    check_eq(tg(i, "rd_addr"), 32'(ram_rd_addr[i]), 32'(rr[i] % int'(DEPTH)));
                    if (ram_rd_addr[i] == AW'(DEPTH - 1)) awrap[i]++;
                    rr[i]++;
                end
                if (ram_wr_en[i]) begin
                    check_eq(tg(i, "wr_room"), 32'(ramc < int'(DEPTH)), 32'd1);
                    check_eq(tg(i, "wr_addr"), 32'(ram_wr_addr[i]), 32'(rw[i] % int'(DEPTH)));
                    check_eq(tg(i, "wr_data"), 32'(ram_wr_data[i]), 32'(push_payload));
                    rw[i]++;
                end
                fp[i] = push_valid && push_ready[i];
                fo[i] = pop_valid[i] && pop_ready;
                if (fp[i]) begin
                    sb[i][wcnt[i] % SBN] = push_payload;
                    wcnt[i]++;
                end
                if (fo[i]) rcnt[i]++;
                prev_stall[i] = pop_valid[i] && !pop_ready;
                prev_pay[i]   = pop_payload[i];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first [2];
        int acc [2];
        int pops [2];
        int gaps [2];
        int wr0 [2];
        logic pr_seen [2];

        for (int i = 0; i < 2; i++) begin
            wcnt[i] = 0; rcnt[i] = 0; rw[i] = 0; rr[i] = 0; awrap[i] = 0;
            prev_stall[i] = 1'b0; prev_pay[i] = '0;
        end

        repeat (3) cyc();
        reset = 1'b0;

        // Single word into an empty FIFO: latency 2+RD_LATENCY, then back to empty.
        pop_ready = 1'b1;
        for (int c = 0; c < 10; c++) cyc();
        push_valid = 1'b1; push_payload = 16'h00A5;
        cyc();
        push_valid = 1'b0;
        first[0] = -1; first[1] = -1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            for (int i = 0; i < 2; i++) if (obs_pv[i] && first[i] < 0) first[i] = k;
        end
        for (int i = 0; i < 2; i++) begin
            check_eq(tg(i, "latency"), 32'(first[i]), 32'(3 + i));
            check_eq(tg(i, "lat_occ0"), 32'(obs_occ[i]), 32'd0);
        end

        // Fill with no pops: DEPTH + RD_LATENCY + 1 words accepted.
        pop_ready = 1'b0; push_valid = 1'b1;
        acc[0] = 0; acc[1] = 0;
        for (int k = 0; k < 12; k++) begin
            push_payload = WIDTH'(k);
            cyc();
            for (int i = 0; i < 2; i++) acc[i] += int'(fp[i]);
        end
        for (int i = 0; i < 2; i++) begin
            check_eq(tg(i, "fill_acc"), 32'(acc[i]), 32'(6 + i));
            check_eq(tg(i, "fill_pr"), 32'(obs_pr[i]), 32'd0);
            check_eq(tg(i, "fill_occ"), 32'(obs_occ[i]), 32'(6 + i));
        end

        // Drain: in order, one per cycle, push_ready recovers.
        push_valid = 1'b0; pop_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin pops[i] = 0; gaps[i] = 0; pr_seen[i] = 1'b0; end
        for (int k = 0; k < 15; k++) begin
            cyc();
            for (int i = 0; i < 2; i++) begin
                if (k == 0) check_eq(tg(i, "drain_pv0"), 32'(obs_pv[i]), 32'd1);
                if (!obs_pv[i] && pops[i] > 0 && pops[i] < 6 + i) gaps[i]++;
                pops[i] += int'(fo[i]);
                pr_seen[i] |= obs_pr[i];
            end
        end
        for (int i = 0; i < 2; i++) begin
            check_eq(tg(i, "drain_pops"), 32'(pops[i]), 32'(6 + i));
            check_eq(tg(i, "drain_gaps"), 32'(gaps[i]), 32'd0);
            check_eq(tg(i, "drain_pr"), 32'(pr_seen[i]), 32'd1);
        end

        // Full-rate streaming with many pointer wraps.
        push_valid = 1'b1; pop_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin acc[i] = 0; pops[i] = 0; gaps[i] = 0; wr0[i] = awrap[i]; end
        for (int k = 0; k < 1010; k++) begin
            if (k == 1000) push_valid = 1'b0;
            push_payload = WIDTH'(16'h1000 + k);
            cyc();
            for (int i = 0; i < 2; i++) begin
                if (!obs_pv[i] && pops[i] > 0 && pops[i] < 1000) gaps[i]++;
                acc[i]  += int'(fp[i]);
                pops[i] += int'(fo[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            check_eq(tg(i, "stream_acc"), 32'(acc[i]), 32'd1000);
            check_eq(tg(i, "stream_pops"), 32'(pops[i]), 32'd1000);
            check_eq(tg(i, "stream_gaps"), 32'(gaps[i]), 32'd0);
            check_eq(tg(i, "stream_wraps"), 32'((awrap[i] - wr0[i]) > 200), 32'd1);
        end

        // Random backpressure, then drain to empty.
        for (int k = 0; k < 800; k++) begin
            push_valid   = ($urandom_range(0, 99) < 70);
            pop_ready    = ($urandom_range(0, 99) < 30);
            push_payload = WIDTH'($urandom);
            cyc();
        end
        push_valid = 1'b0; pop_ready = 1'b1;
        for (int k = 0; k < 20; k++) cyc();
        for (int i = 0; i < 2; i++) check_eq(tg(i, "bp_empty"), 32'(obs_occ[i]), 32'd0);

        // Reset with reads in flight: nothing stale may surface afterwards.
        push_valid = 1'b1; pop_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push_payload = WIDTH'(16'h5000 + k);
            cyc();
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0; push_valid = 1'b0;
        cyc();
        for (int i = 0; i < 2; i++) begin
            check_eq(tg(i, "post_rst_pv"), 32'(obs_pv[i]), 32'd0);
            check_eq(tg(i, "post_rst_occ"), 32'(obs_occ[i]), 32'd0);
            check_eq(tg(i, "post_rst_pr"), 32'(obs_pr[i]), 32'd1);
        end
        for (int k = 0; k < 6; k++) begin
            cyc();
            for (int i = 0; i < 2; i++) check_eq(tg(i, "stale_pv"), 32'(obs_pv[i]), 32'd0);
        end
        push_valid = 1'b1;
        for (int i = 0; i < 2; i++) pops[i] = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) push_valid = 1'b0;
            push_payload = WIDTH'(16'h7000 + k);
            cyc();
            for (int i = 0; i < 2; i++) pops[i] += int'(fo[i]);
        end
        for (int i = 0; i < 2; i++) begin
            check_eq(tg(i, "recover_pops"), 32'(pops[i]), 32'd10);
            check_eq(tg(i, "recover_occ"), 32'(obs_occ[i]), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
